xor_bram_port_arbiter: RTL and testbench

Scheduler sharing one `xor_bram_memory_pipelined` instance (PORTS ports, per-port addr/d/en/q) among NREQ requesters. Each cycle it grants up to PORTS non-conflicting requests in round-robin order and drives them onto the memory ports through registers. It tracks in-flight reads through the memory read latency and returns read data to the issuing requester. It sits between the request fabric and the memory; the memory itself is unchanged.

---
 rtl/xor_bram_arb_pkg.sv | 17 +
 rtl/xor_bram_rd_tracker.sv | 44 ++++
 rtl/xor_bram_port_arbiter.sv | 170 +++++++++++++++++
 tb/tb_xor_bram_port_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/xor_bram_arb_pkg.sv
// Shared types and helpers for the XOR BRAM port arbiter.
// Widths stay with the modules; only width-free definitions live here.
package xor_bram_arb_pkg;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  // Two accesses to one word collide unless both are reads.
  function automatic logic access_conflict(input logic same_addr,
                                           input logic we_a,
                                           input logic we_b);
    return same_addr && (we_a || we_b);
  endfunction

endpackage

// File: rtl/xor_bram_rd_tracker.sv
// Per-port read tracker: carries {valid, requester id} alongside the memory
// read latency and steers the returning word to its requester.
module xor_bram_rd_tracker
  import xor_bram_arb_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int NREQ   = 4,
  parameter  int RD_LAT = 2,
  localparam int IW     = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tag_valid,
  input  logic [IW-1:0]    tag_id,
  input  logic [WIDTH-1:0] mem_q,
  output logic [NREQ-1:0]  rsp_hit,
  output logic [WIDTH-1:0] rsp_q
);

  typedef struct packed {
    logic          valid;
    logic [IW-1:0] id;
  } pipe_tag_t;

  pipe_tag_t pipe [RD_LAT+1];

  // Stage 0 lines up with the registered mem_addr; the last stage lines up with mem_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= RD_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= '{valid: tag_valid, id: tag_id};
      for (int i = 1; i <= RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  always_comb begin
    rsp_hit = '0;
    if (pipe[RD_LAT].valid) rsp_hit[pipe[RD_LAT].id] = 1'b1;
  end

  assign rsp_q = mem_q;

endmodule

// File: rtl/xor_bram_port_arbiter.sv
// Round-robin scheduler sharing a multi-port XOR BRAM among NREQ requesters,
// with conflict-free grants, registered port drive and read-data return.
module xor_bram_port_arbiter
  import xor_bram_arb_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int DEPTH  = 1024,
  parameter  int PORTS  = 2,
  parameter  int NREQ   = 4,
  parameter  int RD_LAT = 2,
  localparam int AW     = $clog2(DEPTH),
  localparam int IW     = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req_valid,
  output logic [NREQ-1:0]  req_ready,
  input  logic [NREQ-1:0]  req_we,
  input  logic [AW-1:0]    req_addr  [NREQ],
  input  logic [WIDTH-1:0] req_wdata [NREQ],
  output logic [NREQ-1:0]  rsp_valid,
  output logic [WIDTH-1:0] rsp_data  [NREQ],
  output logic [AW-1:0]    mem_addr  [PORTS],
  output logic [WIDTH-1:0] mem_d     [PORTS],
  output logic [PORTS-1:0] mem_en,
  input  logic [WIDTH-1:0] mem_q     [PORTS],
  output logic [15:0]      stall_cnt
);

  typedef struct packed {
    op_e              op;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] wdata;
  } req_t;

  typedef struct packed {
    logic             en;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] d;
  } port_cmd_t;

  req_t             req [NREQ];
  port_cmd_t        cmd [PORTS];
  logic [PORTS-1:0] port_used;
  logic [PORTS-1:0] port_rd;
  logic [IW-1:0]    port_id [PORTS];
  logic [NREQ-1:0]  grant;
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    rr_next;
  logic [NREQ-1:0]  hit [PORTS];
  logic [WIDTH-1:0] trk_q [PORTS];
  logic [NREQ-1:0]  rsp_set;
  logic [WIDTH-1:0] rsp_next [NREQ];

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req[i] = '{op: op_e'(req_we[i]), addr: req_addr[i], wdata: req_wdata[i]};
    end
  end

  // Scan from rr_ptr; the k-th accepted request lands on port k.
  always_comb begin
    int            used;
    logic [IW-1:0] idx;
    logic          clash;
    grant     = '0;
    rr_next   = rr_ptr;
    port_used = '0;
    port_rd   = '0;
    used      = 0;
    idx       = '0;
    clash     = 1'b0;
    for (int p = 0; p < PORTS; p++) begin
      cmd[p]     = '0;
      port_id[p] = '0;
    end
    for (int k = 0; k < NREQ; k++) begin
      idx   = IW'((int'(rr_ptr) + k) % NREQ);
      clash = 1'b0;
      for (int j = 0; j < NREQ; j++) begin
        if (grant[j] && access_conflict(req[j].addr == req[idx].addr,
                                        req[j].op == OP_WRITE,
                                        req[idx].op == OP_WRITE))
          clash = 1'b1;
      end
      if (req_valid[idx] && (used < PORTS) && !clash) begin
        grant[idx] = 1'b1;
        for (int p = 0; p < PORTS; p++) begin
          if (used == p) begin
            cmd[p]       = '{en: req[idx].op == OP_WRITE, addr: req[idx].addr, d: req[idx].wdata};
            port_used[p] = 1'b1;
            port_rd[p]   = req[idx].op == OP_READ;
            port_id[p]   = idx;
          end
        end
        rr_next = IW'((int'(idx) + 1) % NREQ);
        used    = used + 1;
      end
    end
  end

  assign req_ready = grant;

  // Idle ports drop the write enable but keep their last address and data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      mem_en    <= '0;
      stall_cnt <= '0;
      for (int p = 0; p < PORTS; p++) begin
        mem_addr[p] <= '0;
        mem_d[p]    <= '0;
      end
    end else begin
      rr_ptr <= rr_next;
      for (int p = 0; p < PORTS; p++) begin
        mem_en[p] <= cmd[p].en;
        if (port_used[p]) begin
          mem_addr[p] <= cmd[p].addr;
          mem_d[p]    <= cmd[p].d;
        end
      end
      if (|(req_valid & ~req_ready) && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

  for (genvar p = 0; p < PORTS; p++) begin : g_trk
    xor_bram_rd_tracker #(
      .WIDTH (WIDTH),
      .NREQ  (NREQ),
      .RD_LAT(RD_LAT)
    ) u_trk (
      .clk      (clk),
      .rst_n    (rst_n),
      .tag_valid(port_rd[p]),
      .tag_id   (port_id[p]),
      .mem_q    (mem_q[p]),
      .rsp_hit  (hit[p]),
      .rsp_q    (trk_q[p])
    );
  end

  // A requester holds at most one read per cycle, so at most one port hits it.
  always_comb begin
    rsp_set = '0;
    for (int i = 0; i < NREQ; i++) rsp_next[i] = '0;
    for (int p = 0; p < PORTS; p++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (hit[p][i]) begin
          rsp_set[i]  = 1'b1;
          rsp_next[i] = trk_q[p];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= '0;
      for (int i = 0; i < NREQ; i++) rsp_data[i] <= '0;
    end else begin
      rsp_valid <= rsp_set;
      for (int i = 0; i < NREQ; i++) begin
        if (rsp_set[i]) rsp_data[i] <= rsp_next[i];
      end
    end
  end

endmodule

// File: tb/tb_xor_bram_port_arbiter.sv
// Directed bench for xor_bram_port_arbiter with a behavioural two-port memory
// and a per-requester response scoreboard checked by an independent monitor.
module tb_xor_bram_port_arbiter;

  localparam int WIDTH  = 32;
  localparam int DEPTH  = 1024;
  localparam int PORTS  = 2;
  localparam int NREQ   = 4;
  localparam int RD_LAT = 2;
  localparam int AW     = 10;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NREQ-1:0]  req_valid;
  logic [NREQ-1:0]  req_ready;
  logic [NREQ-1:0]  req_we;
  logic [AW-1:0]    req_addr  [NREQ];
  logic [WIDTH-1:0] req_wdata [NREQ];
  logic [NREQ-1:0]  rsp_valid;
  logic [WIDTH-1:0] rsp_data  [NREQ];
  logic [AW-1:0]    mem_addr  [PORTS];
  logic [WIDTH-1:0] mem_d     [PORTS];
  logic [PORTS-1:0] mem_en;
  logic [WIDTH-1:0] mem_q     [PORTS];
  logic [15:0]      stall_cnt;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } rsp_exp_t;

  rsp_exp_t exp_q [NREQ][$];

  xor_bram_port_arbiter #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PORTS (PORTS),
    .NREQ  (NREQ),
    .RD_LAT(RD_LAT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .mem_addr (mem_addr),
    .mem_d    (mem_d),
    .mem_en   (mem_en),
    .mem_q    (mem_q),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: unwritten words read as A000_0000 | address.
  logic [31:0] mem_model [DEPTH];
  bit          written   [DEPTH];
  logic [31:0] rd_pipe   [PORTS][RD_LAT];

  always @(posedge clk) begin
    for (int p = 0; p < PORTS; p++) begin
      if (mem_en[p]) begin
        mem_model[mem_addr[p]] <= mem_d[p];
        written[mem_addr[p]]   <= 1'b1;
      end
      rd_pipe[p][0] <= written[mem_addr[p]] ? mem_model[mem_addr[p]]
                                            : (32'hA000_0000 | 32'(mem_addr[p]));
      for (int s = 1; s < RD_LAT; s++) rd_pipe[p][s] <= rd_pipe[p][s-1];
    end
  end

  always_comb begin
    for (int p = 0; p < PORTS; p++) mem_q[p] = rd_pipe[p][RD_LAT-1];
  end

  // Monitor: every rsp_valid must match the oldest expected response of that requester.
  always @(negedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (rsp_valid[i]) begin
        if (exp_q[i].size() == 0) begin
          errors++;
          checks++;
          $display("[TB] FAIL unexpected_rsp req%0d: got data %h, expected no response", i, rsp_data[i]);
        end else begin
          rsp_exp_t e;
          e = exp_q[i].pop_front();
          checks++;
          if (rsp_data[i] !== e.data) begin
            errors++;
            $display("[TB] FAIL rsp_data req%0d: got %h expected %h", i, rsp_data[i], e.data);
          end
          checks++;
          if (cyc != e.cyc) begin
            errors++;
            $display("[TB] FAIL rsp_cycle req%0d: got %0d expected %0d", i, cyc, e.cyc);
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle of stimulus; ready is checked at the negedge and granted reads are scored.
  task automatic applyStimulus(input logic [3:0]   v,
                               input logic [3:0]   we,
                               input logic [39:0]  addrs,
                               input logic [127:0] wdatas,
                               input logic [3:0]   exp_ready,
                               input logic [127:0] exp_rdata,
                               input bit           expect_rsp);
    @(posedge clk);
    #1;
    req_valid = v;
    req_we    = we;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i]  = addrs[i*AW +: AW];
      req_wdata[i] = wdatas[i*32 +: 32];
    end
    @(negedge clk);
    checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
    for (int i = 0; i < NREQ; i++) begin
      if (exp_ready[i] && !we[i] && expect_rsp) begin
        rsp_exp_t e;
        e.data = exp_rdata[i*32 +: 32];
        e.cyc  = cyc + 4;
        exp_q[i].push_back(e);
      end
    end
  endtask

  task automatic idleCycle();
    applyStimulus(4'b0000, 4'b0000, '0, '0, 4'b0000, '0, 1'b0);
  endtask

  localparam logic [39:0]  ADDR_0123 = {10'd3, 10'd2, 10'd1, 10'd0};
  localparam logic [127:0] DATA_0123 = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_we    = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i]  = '0;
      req_wdata[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("reset_mem_en", 32'(mem_en), 32'h0);
    checkOutput("reset_mem_addr1", 32'(mem_addr[1]), 32'h0);
    checkOutput("reset_stall_cnt", 32'(stall_cnt), 32'h0);
    rst_n = 1'b1;

    // All four read distinct words continuously: pairs {0,1},{2,3} alternate.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(4'b1111, 4'b0000, ADDR_0123, '0, 4'b0011, DATA_0123, 1'b1);
      if (k > 0) begin
        checkOutput("rr_mem_addr0_b", 32'(mem_addr[0]), 32'd2);
        checkOutput("rr_mem_addr1_b", 32'(mem_addr[1]), 32'd3);
      end
      applyStimulus(4'b1111, 4'b0000, ADDR_0123, '0, 4'b1100, DATA_0123, 1'b1);
      checkOutput("rr_mem_addr0_a", 32'(mem_addr[0]), 32'd0);
      checkOutput("rr_mem_addr1_a", 32'(mem_addr[1]), 32'd1);
    end
    idleCycle();
    checkOutput("stall_cnt_6", 32'(stall_cnt), 32'd6);
    repeat (3) idleCycle();

    // Write then read of the same word: read deferred one cycle and sees the write.
    applyStimulus(4'b0011, 4'b0001, {20'd0, 10'd5, 10'd5}, {96'h0, 32'hDEADBEEF},
                  4'b0001, '0, 1'b1);
    applyStimulus(4'b0010, 4'b0000, {20'd0, 10'd5, 10'd0}, '0,
                  4'b0010, {64'h0, 32'hDEADBEEF, 32'h0}, 1'b1);
    checkOutput("wr_mem_en", 32'(mem_en), 32'h1);
    checkOutput("wr_mem_addr0", 32'(mem_addr[0]), 32'd5);
    checkOutput("wr_mem_d0", mem_d[0], 32'hDEADBEEF);

    // Bring rr_ptr back to 0, then two writers race for word 9.
    applyStimulus(4'b1000, 4'b0000, {10'd100, 30'd0}, '0,
                  4'b1000, {32'hA000_0064, 96'h0}, 1'b1);
    applyStimulus(4'b1100, 4'b1100, {10'd9, 10'd9, 20'd0}, {32'h3333_4444, 32'h1111_2222, 64'h0},
                  4'b0100, '0, 1'b1);
    applyStimulus(4'b1000, 4'b1000, {10'd9, 10'd9, 20'd0}, {32'h3333_4444, 32'h1111_2222, 64'h0},
                  4'b1000, '0, 1'b1);
    checkOutput("ww_mem_d0", mem_d[0], 32'h1111_2222);
    applyStimulus(4'b0001, 4'b0000, {30'd0, 10'd9}, '0,
                  4'b0001, {96'h0, 32'h3333_4444}, 1'b1);

    // Two reads of one word are co-granted and return together.
    applyStimulus(4'b0011, 4'b0000, {20'd0, 10'd7, 10'd7}, '0,
                  4'b0011, {64'h0, 32'hA000_0007, 32'hA000_0007}, 1'b1);
    idleCycle();
    checkOutput("rr_same_addr0", 32'(mem_addr[0]), 32'd7);
    checkOutput("rr_same_addr1", 32'(mem_addr[1]), 32'd7);
    repeat (5) idleCycle();

    // Reads in flight when reset hits must never respond.
    applyStimulus(4'b0011, 4'b0000, {20'd0, 10'd21, 10'd20}, '0, 4'b0011, '0, 1'b0);
    idleCycle();
    idleCycle();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("midrst_rsp_data0", rsp_data[0], 32'h0);
    checkOutput("midrst_mem_addr0", 32'(mem_addr[0]), 32'h0);
    checkOutput("midrst_mem_d0", mem_d[0], 32'h0);
    checkOutput("midrst_stall_cnt", 32'(stall_cnt), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) idleCycle();

    // Two writers of one word stall each other every cycle until the counter saturates.
    @(posedge clk);
    #1;
    req_valid    = 4'b0011;
    req_we       = 4'b0011;
    req_addr[0]  = 10'd50;
    req_addr[1]  = 10'd50;
    req_wdata[0] = 32'h5555_0000;
    req_wdata[1] = 32'h5555_0001;
    repeat (1000) @(posedge clk);
    @(negedge clk);
    checkOutput("stall_cnt_1000", 32'(stall_cnt), 32'd1000);
    repeat (69000) @(posedge clk);
    @(negedge clk);
    checkOutput("stall_cnt_sat", 32'(stall_cnt), 32'h0000_FFFF);
    idleCycle();
    checkOutput("stall_cnt_hold", 32'(stall_cnt), 32'h0000_FFFF);

    repeat (8) idleCycle();
    for (int i = 0; i < NREQ; i++) begin
      checkOutput($sformatf("pending_rsp_req%0d", i), 32'(exp_q[i].size()), 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
